addsub_chunk_serial: RTL

Parametrised, chunk-serial two's-complement adder/subtractor with a valid/ready handshake on input and output. It is the multi-cycle successor of the 16-bit combinational add/sub unit. It computes A+B or A−B over `WIDTH/CHUNK` clock cycles, using one `CHUNK`-bit adder slice and a registered carry, so wide operands cost little area. It sits between operand-issue logic and result writeback in the datapath.

---
 rtl/addsub_chunk_serial.sv | 135 +++++++++++++
 1 files changed

// File: rtl/addsub_chunk_serial.sv
// Chunk-serial two's-complement adder/subtractor with valid/ready on both sides.
// Optional saturation of SUM on signed overflow when ADDSUB_SAT_EN is defined.
module addsub_chunk_serial #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Add_ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] SUM,
    output logic             C_out,
    output logic             O
);

    // state  | meaning
    // S_IDLE | waiting for operands, in_ready=1
    // S_BUSY | one CHUNK-bit slice per cycle, LSB chunk first
    // S_DONE | result held, out_valid=1 until out_ready

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_out_q, c_out_d;
    logic             o_q, o_d;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;
    logic             msb_cin;
    logic             last_chunk;

    always_comb begin
        a_chunk = a_q[cnt_q*CHUNK +: CHUNK];
        b_chunk = b_q[cnt_q*CHUNK +: CHUNK];
        {chunk_cout, chunk_sum} = {1'b0, a_chunk} + {1'b0, b_chunk}
                                + {{CHUNK{1'b0}}, carry_q};
        // Carry into the top bit of the slice, recovered from its sum bit.
        msb_cin    = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];
        last_chunk = (cnt_q == CW'(N - 1));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        o_d     = o_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B ^ {WIDTH{Add_ctrl}};
                    carry_d = Add_ctrl;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                sum_d[cnt_q*CHUNK +: CHUNK] = chunk_sum;
                carry_d = chunk_cout;
                cnt_d   = cnt_q + 1'b1;
                if (last_chunk) begin
                    c_out_d = chunk_cout;
                    o_d     = msb_cin ^ chunk_cout;
                    state_d = S_DONE;
`ifdef ADDSUB_SAT_EN
                    // Overflow implies both effective signs match; a_q's sign picks the limit.
                    if (msb_cin ^ chunk_cout) begin
                        sum_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                             : {1'b0, {(WIDTH-1){1'b1}}};
                    end
`endif
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            o_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            o_q     <= o_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign SUM       = sum_q;
    assign C_out     = c_out_q;
    assign O         = o_q;

endmodule
